// File: rtl/program_counter_pkg.sv
// Shared processor constants for the WideWord fetch stage.
// Vectors are big-endian: bit 0 is the MSB.
package program_counter_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [0:PC_WIDTH-1] pc_t;

    localparam pc_t PC_RESET_VALUE = 32'h0000_0000;

endpackage : program_counter_pkg

// File: rtl/program_counter_pc_incrementer.sv
// Adds a constant to a big-endian (bit 0 = MSB) operand modulo 2^WIDTH.
// The adder uses 4-bit carry-lookahead groups chained from the LSB end.
module pc_incrementer
    import program_counter_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int INCR  = INSTR_BYTES
) (
    input  logic [0:WIDTH-1] operand,
    output logic [0:WIDTH-1] sum
);

    localparam logic [0:WIDTH-1] INCR_C = WIDTH'(INCR);
    localparam int NGRP = (WIDTH + 3) / 4;

    logic [0:WIDTH-1] gen_s;
    logic [0:WIDTH-1] prop_s;
    logic [0:WIDTH-1] carry_s;
    logic             carry_unused_s;

    assign gen_s  = operand & INCR_C;
    assign prop_s = operand ^ INCR_C;

    // Group k covers LSB-relative bits 4k..4k+3, i.e. index WIDTH-1-4k downwards.
    for (genvar grp = 0; grp < NGRP; grp++) begin : g_grp
        localparam int LO = 4 * grp;
        localparam int NB = ((WIDTH - LO) < 4) ? (WIDTH - LO) : 4;

        logic cin_s;
        logic cout_s;

        if (grp == 0) begin : g_first
            assign cin_s = 1'b0;
        end else begin : g_next
            assign cin_s = g_grp[grp-1].cout_s;
        end

        // Each bit's carry comes from the group-prefix generate/propagate plus the group carry-in.
        for (genvar k = 0; k < NB; k++) begin : g_bit
            localparam int IDX = WIDTH - 1 - LO - k;

            logic pg_s;
            logic pp_s;

            if (k == 0) begin : g_lsb
                assign carry_s[IDX] = cin_s;
                assign pg_s         = gen_s[IDX];
                assign pp_s         = prop_s[IDX];
            end else begin : g_upper
                assign carry_s[IDX] = g_bit[k-1].pg_s | (g_bit[k-1].pp_s & cin_s);
                assign pg_s         = gen_s[IDX] | (prop_s[IDX] & g_bit[k-1].pg_s);
                assign pp_s         = prop_s[IDX] & g_bit[k-1].pp_s;
            end
        end

        assign cout_s = g_bit[NB-1].pg_s | (g_bit[NB-1].pp_s & cin_s);
    end

    // Carry out of the MSB is discarded so the PC wraps.
    assign carry_unused_s = g_grp[NGRP-1].cout_s;

    assign sum = prop_s ^ carry_s;

endmodule : pc_incrementer

// File: rtl/program_counter.sv
// Registered sequential-PC generator: next_pc <= cur_pc + INCR every rising edge.
// Asynchronous active-low reset loads RESET_PC.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int               WIDTH    = PC_WIDTH,
    parameter int               INCR     = INSTR_BYTES,
    parameter logic [0:WIDTH-1] RESET_PC = PC_RESET_VALUE
) (
    output logic [0:WIDTH-1] next_pc,
    input  logic [0:WIDTH-1] cur_pc,
    input  logic             rst,
    input  logic             clk
);

    logic [0:WIDTH-1] sum_s;

    pc_incrementer #(
        .WIDTH (WIDTH),
        .INCR  (INCR)
    ) u_incr (
        .operand (cur_pc),
        .sum     (sum_s)
    );

    // Output register; reset wins over a coincident clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_pc <= RESET_PC;
        end else begin
            next_pc <= sum_s;
        end
    end

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter: reset, increment, feedback,
// wrap, asynchronous reset mid-run and mid-cycle input changes.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] cur_pc;
    logic [0:31] next_pc;

    int vectors    = 0;
    int miscompares = 0;

    program_counter #(
        .WIDTH    (32),
        .INCR     (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .next_pc (next_pc),
        .cur_pc  (cur_pc),
        .rst     (rst),
        .clk     (clk)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        exp = 32'h0000_0000;
        rst = 1'b1;
        cur_pc = $urandom;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (next_pc !== exp) begin
            miscompares++;
            $display("FAIL reset_immediate: got %h expected %h", next_pc, exp);
        end
        for (int i = 0; i < 3; i++) begin
            cur_pc = $urandom;
            tick();
            vectors++;
            if (next_pc !== exp) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, next_pc, exp);
            end
        end
    endtask

    task automatic test_single_increment();
        cur_pc = 32'd200;
        rst = 1'b1;
        #1;
        vectors++;
        if (next_pc !== 32'd0) begin
            miscompares++;
            $display("FAIL release_no_update: got %h expected %h", next_pc, 32'd0);
        end
        tick();
        vectors++;
        if (next_pc !== 32'd204) begin
            miscompares++;
            $display("FAIL single_increment: got %0d expected %0d", next_pc, 32'd204);
        end
    endtask

    task automatic test_feedback();
        logic [31:0] exp;
        cur_pc = 32'd200;
        exp = 32'd204;
        tick();
        tick();
        vectors++;
        if (next_pc !== exp) begin
            miscompares++;
            $display("FAIL feedback_start: got %0d expected %0d", next_pc, exp);
        end
        for (int i = 0; i < 16; i++) begin
            cur_pc = next_pc;
            exp = exp + 32'd4;
            tick();
            vectors++;
            if (next_pc !== exp) begin
                miscompares++;
                $display("FAIL feedback_step[%0d]: got %0d expected %0d", i, next_pc, exp);
            end
            tick();
            vectors++;
            if (next_pc !== exp) begin
                miscompares++;
                $display("FAIL feedback_hold[%0d]: got %0d expected %0d", i, next_pc, exp);
            end
        end
        vectors++;
        if (exp !== 32'd268 || next_pc !== 32'd268) begin
            miscompares++;
            $display("FAIL feedback_final: got %0d expected %0d", next_pc, 32'd268);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] stim [6];
        logic [31:0] expv [6];
        stim[0] = 32'hFFFF_FFFC; expv[0] = 32'h0000_0000;
        stim[1] = 32'h7FFF_FFFC; expv[1] = 32'h8000_0000;
        stim[2] = 32'hFFFF_FFFF; expv[2] = 32'h0000_0003;
        stim[3] = 32'h0000_FFFC; expv[3] = 32'h0001_0000;
        stim[4] = 32'h0000_0102; expv[4] = 32'h0000_0106;
        stim[5] = 32'h1234_567D; expv[5] = 32'h1234_5681;
        for (int i = 0; i < 6; i++) begin
            cur_pc = stim[i];
            tick();
            vectors++;
            if (next_pc !== expv[i]) begin
                miscompares++;
                $display("FAIL wrap[%0d] cur=%h: got %h expected %h", i, stim[i], next_pc, expv[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        cur_pc = 32'h0000_00FC;
        tick();
        vectors++;
        if (next_pc !== 32'h0000_0100) begin
            miscompares++;
            $display("FAIL async_pre: got %h expected %h", next_pc, 32'h0000_0100);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (next_pc !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL async_assert: got %h expected %h", next_pc, 32'h0000_0000);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (next_pc !== 32'h0000_0000) begin
                miscompares++;
                $display("FAIL async_hold[%0d]: got %h expected %h", i, next_pc, 32'h0000_0000);
            end
        end
        cur_pc = 32'h0000_0300;
        rst = 1'b1;
        #1;
        vectors++;
        if (next_pc !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL async_release_wait: got %h expected %h", next_pc, 32'h0000_0000);
        end
        tick();
        vectors++;
        if (next_pc !== 32'h0000_0304) begin
            miscompares++;
            $display("FAIL async_release_load: got %h expected %h", next_pc, 32'h0000_0304);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] seq [3];
        seq[0] = 32'd1;
        seq[1] = 32'd5;
        seq[2] = 32'd9;
        for (int i = 0; i < 3; i++) begin
            cur_pc = seq[i];
            #1;
            vectors++;
            if (next_pc !== 32'h0000_0304) begin
                miscompares++;
                $display("FAIL glitch_between[%0d]: got %h expected %h", i, next_pc, 32'h0000_0304);
            end
        end
        tick();
        vectors++;
        if (next_pc !== 32'd13) begin
            miscompares++;
            $display("FAIL glitch_edge: got %0d expected %0d", next_pc, 32'd13);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cur_pc = 32'h0000_0000;
        test_reset();
        test_single_increment();
        test_feedback();
        test_wrap();
        test_async_reset();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_program_counter
